minx16_ctx_xfer: RTL and testbench
==================================

# minx16_ctx_xfer

Context save/restore engine for the Minx16 16-bit register file. It drives the register file's read port A and its byte-lane write port to stream every register out as bytes (save) or in from bytes (restore). The byte stream uses a valid/ready handshake. The block sits between the register file and the debug/interrupt context path. It is the master end of the register file's address/data/write-mode interface.

## Interface
- A, 3, register address width; N = 2**A registers, all transferred, index 0 first
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a transfer; sampled only in IDLE
- mode  input  1  0 = save (regfile → so_*), 1 = restore (si_* → regfile); sampled with start
- abort  input  1  terminate any transfer; takes priority over everything except rst
- busy  output  1  high from the cycle after start is accepted until the transfer ends
- done  output  1  one-cycle pulse on normal completion; no pulse on abort
- rf_ra  output  A  register file read address A
- rf_da  input  16  register file read data A; valid one cycle after rf_ra changes
- rf_rd  output  A  register file write address
- rf_dd  output  16  register file write data
- rf_wd  output  3  write mode: 000 keep, 001 low byte from dd[7:0], 010 high byte from dd[15:8]; no other codes are issued
- so_valid  output  1  save byte valid
- so_ready  input  1  save byte accepted
- so_data  output  8  save byte
- si_valid  input  1  restore byte valid
- si_ready  output  1  restore byte accepted
- si_data  input  8  restore byte

## Operation
- States: IDLE, S_RD, S_HI, S_LO, R_HI, R_LO, DONE.
- Internal index register idx (A bits) drives both rf_ra and rf_rd.
- idx, rf_ra and rf_rd are registered and therefore stable across the whole cycle.
- IDLE + start: idx ← 0, then go to S_RD (mode 0) or R_HI (mode 1). start is ignored in any other state.
- S_RD: one cycle. At its closing edge, hold ← rf_da, then go to S_HI.
- S_HI: so_valid = 1, so_data = hold[15:8]. On so_ready, go to S_LO.
- S_LO: so_valid = 1, so_data = hold[7:0]. On so_ready: if idx = N-1, go to DONE; otherwise idx ← idx+1 and go to S_RD.
- R_HI: si_ready = 1. On si_valid, issue rf_wd = 010 and rf_dd = {si_data, 8'h00} in the same cycle, then go to R_LO.
- R_LO: si_ready = 1. On si_valid, issue rf_wd = 001 and rf_dd = {8'h00, si_data}. Then go to DONE if idx = N-1; otherwise idx ← idx+1 and go to R_HI.
- DONE: done = 1 for one cycle, then go to IDLE.
- Byte order on both streams: high byte first, registers in ascending index order.
- rf_wd = 000 in every cycle without a restore handshake, so the register file content is unchanged.
- rf_dd = 16'h0000 whenever rf_wd = 000.
- so_data is held stable while so_valid && !so_ready.
- busy = 1 in every state except IDLE.

## Timing
- Reset values: state IDLE, idx 0, rf_ra 0, rf_rd 0, rf_dd 0, rf_wd 000, hold 0, busy 0, done 0, so_valid 0, so_data 0, si_ready 0.
- rst mid-transfer: IDLE at the next edge. A restore may be left partially written; this is acceptable.
- abort in any non-IDLE state: IDLE at the next edge, no done. A handshake in the abort cycle is not completed: rf_wd is forced to 000, si_ready to 0 and so_valid to 0 in that cycle.
- Save with so_ready held high: 3 cycles per register, done 3N+1 cycles after start (25 for A=3).
- Restore with si_valid held high: 2 cycles per register, done 2N+1 cycles after start (17 for A=3).
- Restore write latency: the register value is visible on the register file read port 2 cycles after the R_LO handshake.
- Backpressure: any number of stall cycles in S_HI, S_LO, R_HI or R_LO. No byte is lost or duplicated.
- start asserted in the same cycle as done (DONE state): ignored. A new transfer is accepted only in IDLE.

## Structure
- Package minx16_ctx_pkg contains:
  - state enum;
  - MODE_SAVE / MODE_RESTORE;
  - write-mode constants WD_KEEP = 3'b000, WD_LO = 3'b001, WD_HI = 3'b010, shared with the register file's users.
- Single module, no sub-module. The FSM, idx counter and hold register are all local.

## Test plan
- Save, A=3, registers preset 0x1100+i, so_ready = 1 → so_data sequence 11 00, 11 01, …, 11 07 (16 bytes); done 25 cycles after start; rf_wd = 000 throughout.
- Restore, bytes 0xA0..0xAF with si_valid = 1 → r0 = 0xA0A1, …, r7 = 0xAEAF; done 17 cycles after start; then save returns the same 16 bytes.
- Save with so_ready toggling 1-0-1-0 → same byte stream; so_data stable during every stall; completion delayed by exactly the stall count.
- Restore, abort during R_LO of r3 (high byte 0x5A already written) → r3[15:8] = 0x5A, r3[7:0] unchanged, r4..r7 unchanged; no done; busy = 0 the next cycle.
- start pulsed while busy and in the DONE cycle → ignored. Back-to-back save then restore → each produces exactly one done.
- rst asserted mid-save → all outputs return to reset values at the next edge; so_valid drops immediately.

Source files
------------

// File: rtl/minx16_ctx_xfer_pkg.sv
// Shared types and constants for the Minx16 context save/restore engine.
// WD_* codes are the register file's byte-lane write modes.
package minx16_ctx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S_RD,
    ST_S_HI,
    ST_S_LO,
    ST_R_HI,
    ST_R_LO,
    ST_DONE
  } ctx_state_t;

  localparam logic MODE_SAVE    = 1'b0;
  localparam logic MODE_RESTORE = 1'b1;

  localparam logic [2:0] WD_KEEP = 3'b000;
  localparam logic [2:0] WD_LO   = 3'b001;
  localparam logic [2:0] WD_HI   = 3'b010;

endpackage

// File: rtl/minx16_ctx_xfer_if.sv
// Register file port plus the save/restore byte streams.
// Handshake: a byte moves in a cycle where valid && ready are both high at the
// clock edge; the source holds data stable while valid && !ready.
interface minx16_ctx_xfer_if #(parameter int A = 3);

  logic [A-1:0] rf_ra;
  logic [15:0]  rf_da;
  logic [A-1:0] rf_rd;
  logic [15:0]  rf_dd;
  logic [2:0]   rf_wd;

  logic         so_valid;
  logic         so_ready;
  logic [7:0]   so_data;

  logic         si_valid;
  logic         si_ready;
  logic [7:0]   si_data;

  modport master (
    output rf_ra, rf_rd, rf_dd, rf_wd, so_valid, so_data, si_ready,
    input  rf_da, so_ready, si_valid, si_data
  );

  modport slave (
    input  rf_ra, rf_rd, rf_dd, rf_wd, so_valid, so_data, si_ready,
    output rf_da, so_ready, si_valid, si_data
  );

endinterface

// File: rtl/minx16_ctx_xfer.sv
// Streams every Minx16 register out as bytes (save) or in from bytes (restore),
// high byte first, registers in ascending index order.
module minx16_ctx_xfer
  import minx16_ctx_pkg::*;
#(
  parameter int A = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output ctx_state_t dbg_state,
  minx16_ctx_xfer_if.master bus
);

  localparam logic [A-1:0] IDX_LAST = {A{1'b1}};

  ctx_state_t   state_q, state_d;
  logic [A-1:0] idx_q, idx_d;
  logic [15:0]  hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // abort wins over every transition, including a start seen in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_d   = '0;
            state_d = (mode == MODE_RESTORE) ? ST_R_HI : ST_S_RD;
          end
        end
        ST_S_RD: begin
          hold_d  = bus.rf_da;
          state_d = ST_S_HI;
        end
        ST_S_HI: begin
          if (bus.so_ready) state_d = ST_S_LO;
        end
        ST_S_LO: begin
          if (bus.so_ready) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_S_RD;
            end
          end
        end
        ST_R_HI: begin
          if (bus.si_valid) state_d = ST_R_LO;
        end
        ST_R_LO: begin
          if (bus.si_valid) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_R_HI;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Restore writes are issued combinationally in the handshake cycle itself.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE) && !abort;
    bus.so_valid = 1'b0;
    bus.so_data  = 8'h00;
    bus.si_ready = 1'b0;
    bus.rf_wd    = WD_KEEP;
    bus.rf_dd    = 16'h0000;
    case (state_q)
      ST_S_HI: begin
        bus.so_valid = !abort;
        bus.so_data  = hold_q[15:8];
      end
      ST_S_LO: begin
        bus.so_valid = !abort;
        bus.so_data  = hold_q[7:0];
      end
      ST_R_HI: begin
        bus.si_ready = !abort;
        if (bus.si_valid && !abort) begin
          bus.rf_wd = WD_HI;
          bus.rf_dd = {bus.si_data, 8'h00};
        end
      end
      ST_R_LO: begin
        bus.si_ready = !abort;
        if (bus.si_valid && !abort) begin
          bus.rf_wd = WD_LO;
          bus.rf_dd = {8'h00, bus.si_data};
        end
      end
      default: ;
    endcase
  end

  assign bus.rf_ra = idx_q;
  assign bus.rf_rd = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_minx16_ctx_xfer.sv
// Bench for minx16_ctx_xfer: a small register file model, a table of save/restore
// runs with randomized backpressure, and hand-written abort/start/reset sequences.
module tb_minx16_ctx_xfer;
  import minx16_ctx_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic       abort;
  logic       busy;
  logic       done;
  ctx_state_t dbg_state;
  logic       load_preset;

  minx16_ctx_xfer_if #(.A(3)) bus();

  minx16_ctx_xfer #(.A(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Register file model: asynchronous read port A, byte-lane write port.
  logic [15:0] regs[N];
  logic [15:0] ref_regs[N];
  assign bus.rf_da = regs[bus.rf_ra];

  always @(posedge clk) begin
    if (load_preset) begin
      for (int i = 0; i < N; i++) regs[i] <= 16'h1100 + 16'(i);
    end else begin
      case (bus.rf_wd)
        WD_HI:   regs[bus.rf_rd][15:8] <= bus.rf_dd[15:8];
        WD_LO:   regs[bus.rf_rd][7:0]  <= bus.rf_dd[7:0];
        default: ;
      endcase
    end
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic pick(input int pat, input int pct, input int c);
    if (pat == 0) return 1'b1;
    if (pat == 1) return (c % 2) == 1;
    return $urandom_range(99) >= pct;
  endfunction

  task automatic check_regs(input string nm);
    for (int i = 0; i < N; i++) check(nm, {16'(i), regs[i]}, {16'(i), ref_regs[i]});
  endtask

  task automatic run_save(input int pat, input int pct, input int exp_base);
    int stalls = 0;
    int dcyc = -1;
    int wd_bad = 0;
    int unstable = 0;
    int extra = 0;
    bit prev_stall = 0;
    logic [7:0] last_data = 8'h00;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(ref_regs[i][15:8]);
      exp_q.push_back(ref_regs[i][7:0]);
    end
    @(negedge clk);
    start = 1'b1; mode = MODE_SAVE; bus.so_ready = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      bus.so_ready = pick(pat, pct, c);
      #1;
      if (bus.rf_wd !== WD_KEEP || bus.rf_dd !== 16'h0) wd_bad++;
      if (prev_stall && (bus.so_data !== last_data || !bus.so_valid)) unstable++;
      prev_stall = bus.so_valid && !bus.so_ready;
      if (prev_stall) begin
        stalls++;
        last_data = bus.so_data;
      end
      if (bus.so_valid && bus.so_ready) begin
        if (exp_q.size() == 0) extra++;
        else check("save_byte", bus.so_data, exp_q.pop_front());
      end
      if (done) begin
        dcyc = c;
        break;
      end
    end
    bus.so_ready = 1'b0;
    check("save_done_cycle", dcyc, exp_base + stalls);
    check("save_left_bytes", exp_q.size() + extra, 0);
    check("save_wd_keep", wd_bad, 0);
    check("save_data_stable", unstable, 0);
    @(negedge clk); #1;
    check("save_done_pulse", {busy, done}, 2'b00);
  endtask

  task automatic run_restore(input int kind, input int pat, input int pct, input int exp_base);
    logic [7:0] b[2*N];
    int stalls = 0;
    int dcyc = -1;
    int so_bad = 0;
    for (int k = 0; k < 2*N; k++) b[k] = (kind == 0) ? 8'hA0 + 8'(k) : 8'($urandom_range(255));
    src_q.delete();
    for (int k = 0; k < 2*N; k++) src_q.push_back(b[k]);
    @(negedge clk);
    start = 1'b1; mode = MODE_RESTORE; bus.si_valid = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      bus.si_valid = (src_q.size() > 0) && pick(pat, pct, c);
      bus.si_data  = bus.si_valid ? src_q[0] : 8'($urandom_range(255));
      #1;
      if (bus.so_valid) so_bad++;
      if (bus.si_ready && !bus.si_valid) stalls++;
      if (bus.si_ready && bus.si_valid) void'(src_q.pop_front());
      if (done) begin
        dcyc = c;
        break;
      end
    end
    bus.si_valid = 1'b0;
    for (int i = 0; i < N; i++) ref_regs[i] = {b[2*i], b[2*i+1]};
    check("restore_done_cycle", dcyc, exp_base + stalls);
    check("restore_left_bytes", src_q.size(), 0);
    check("restore_no_so", so_bad, 0);
    @(negedge clk); #1;
    check("restore_done_pulse", {busy, done}, 2'b00);
    check_regs("restore_reg");
  endtask

  typedef struct {
    bit mode;
    int pat;
    int pct;
    int kind;
    int exp_base;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{MODE_SAVE,    0, 0,  0, 3*N+1};
    vecs[1] = '{MODE_RESTORE, 0, 0,  0, 2*N+1};
    vecs[2] = '{MODE_SAVE,    0, 0,  0, 3*N+1};
    vecs[3] = '{MODE_SAVE,    1, 0,  0, 3*N+1};
    vecs[4] = '{MODE_RESTORE, 2, 30, 1, 2*N+1};
    vecs[5] = '{MODE_SAVE,    2, 40, 0, 3*N+1};
    vecs[6] = '{MODE_RESTORE, 1, 0,  1, 2*N+1};
    vecs[7] = '{MODE_SAVE,    2, 60, 0, 3*N+1};

    rst = 1'b1; load_preset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    bus.so_ready = 1'b0; bus.si_valid = 1'b0; bus.si_data = 8'h00;
    for (int i = 0; i < N; i++) ref_regs[i] = 16'h1100 + 16'(i);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_busy_done", {busy, done}, 2'b00);
    check("reset_so", {bus.so_valid, bus.so_data}, 9'h0);
    check("reset_rf", {bus.rf_ra, bus.rf_rd, bus.rf_wd, bus.rf_dd, bus.si_ready}, 26'h0);
    check("reset_state", dbg_state, ST_IDLE);
    rst = 1'b0; load_preset = 1'b0;

    foreach (vecs[v]) begin
      if (vecs[v].mode == MODE_SAVE) run_save(vecs[v].pat, vecs[v].pct, vecs[v].exp_base);
      else run_restore(vecs[v].kind, vecs[v].pat, vecs[v].pct, vecs[v].exp_base);
    end

    // Abort in R_LO of r3 after its high byte 0x5A has been written.
    begin
      logic [7:0] b[2*N];
      int hs = 0;
      bit hit = 0;
      for (int k = 0; k < 2*N; k++) b[k] = 8'h50 + 8'(k);
      b[6] = 8'h5A;
      @(negedge clk);
      start = 1'b1; mode = MODE_RESTORE;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        start = 1'b0;
        bus.si_valid = 1'b1;
        bus.si_data  = b[hs];
        abort = (hs == 7);
        #1;
        if (abort) begin
          check("abort_wd", bus.rf_wd, WD_KEEP);
          check("abort_si_ready", bus.si_ready, 1'b0);
          check("abort_no_done", done, 1'b0);
          hit = 1;
          break;
        end
        if (bus.si_ready && bus.si_valid) hs++;
      end
      check("abort_reached", hit, 1'b1);
      @(negedge clk);
      abort = 1'b0; bus.si_valid = 1'b0;
      #1;
      check("abort_busy_low", {busy, done}, 2'b00);
      for (int i = 0; i < 3; i++) ref_regs[i] = {b[2*i], b[2*i+1]};
      ref_regs[3][15:8] = 8'h5A;
      check_regs("abort_reg");
    end

    // start pulsed while busy and in the DONE cycle is ignored.
    begin
      int dcnt = 0;
      int first = -1;
      int busy_after = 0;
      @(negedge clk);
      start = 1'b1; mode = MODE_SAVE;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        start = (c == 5) || (c == 25);
        mode  = MODE_RESTORE;
        bus.so_ready = 1'b1;
        #1;
        if (done) begin
          dcnt++;
          if (first < 0) first = c;
        end
        if (c > 25 && busy) busy_after++;
      end
      start = 1'b0; bus.so_ready = 1'b0;
      check("ign_start_done_cnt", dcnt, 1);
      check("ign_start_done_cyc", first, 3*N+1);
      check("ign_start_idle", busy_after, 0);
    end

    // Back-to-back save then restore: one done each.
    begin
      int dc[$];
      @(negedge clk);
      start = 1'b1; mode = MODE_SAVE;
      src_q.delete();
      for (int k = 0; k < 2*N; k++) src_q.push_back(8'($urandom_range(255)));
      for (int i = 0; i < N; i++) ref_regs[i] = {src_q[2*i], src_q[2*i+1]};
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        start = (c == 3*N+2);
        mode  = MODE_RESTORE;
        bus.so_ready = 1'b1;
        bus.si_valid = src_q.size() > 0;
        bus.si_data  = bus.si_valid ? src_q[0] : 8'h00;
        #1;
        if (bus.si_ready && bus.si_valid) void'(src_q.pop_front());
        if (done) dc.push_back(c);
      end
      start = 1'b0; bus.so_ready = 1'b0; bus.si_valid = 1'b0;
      check("b2b_done_cnt", dc.size(), 2);
      if (dc.size() == 2) begin
        check("b2b_save_cyc", dc[0], 3*N+1);
        check("b2b_restore_cyc", dc[1], 3*N+2 + 2*N+1);
      end
      check_regs("b2b_reg");
    end

    // Synchronous reset in the middle of a save.
    begin
      @(negedge clk);
      start = 1'b1; mode = MODE_SAVE;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        start = 1'b0;
        bus.so_ready = 1'b1;
        rst = (c == 10);
      end
      #1;
      check("rst_pre_edge_busy", busy, 1'b1);
      @(negedge clk);
      rst = 1'b0; bus.so_ready = 1'b0;
      #1;
      check("rst_busy_done", {busy, done}, 2'b00);
      check("rst_so", {bus.so_valid, bus.so_data}, 9'h0);
      check("rst_rf", {bus.rf_ra, bus.rf_rd, bus.rf_wd, bus.rf_dd, bus.si_ready}, 26'h0);
      check("rst_state", dbg_state, ST_IDLE);
    end

    run_save(0, 0, 3*N+1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
